kcore_start_token_arbiter: RTL and testbench

- Shares one start-token FIFO write port (HLS-style start FIFO, if_write/if_full_n handshake, depth 4) among NUM_REQ upstream dataflow processes in the kcore kernel.
- Round-robin grant; each requester holds a per-requester credit counter that caps its outstanding (issued, not yet done) tokens.
- The requester ID is tagged into the FIFO word. The downstream write_back process returns done_valid/done_id, which frees the credit.

---
 rtl/kcore_start_token_arbiter.sv | 157 +++++++++++++++
 tb/tb_kcore_start_token_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/kcore_start_token_arbiter.sv
// Round-robin, credit-limited arbiter sharing one HLS start-FIFO write port among NUM_REQ producers.
// Define KCORE_START_ARB_STATS_EN to add per-requester grant counters and a stall counter.
module kcore_start_token_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int DATA_WIDTH = 1,
  parameter int MAX_CREDIT = 4,
  parameter int CNT_W      = 3,
  parameter int TOT_W      = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full_n,
  output logic                          fifo_write,
  output logic [ID_W+DATA_WIDTH-1:0]    fifo_din,
  input  logic                          done_valid,
  input  logic [ID_W-1:0]               done_id,
  output logic [TOT_W-1:0]              outstanding,
  output logic                          idle,
`ifdef KCORE_START_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]         grant_cnt,
  output logic [15:0]                   stall_cnt,
`endif
  output logic                          err_underflow
);

  logic [ID_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]      credit [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    dec;
  logic                  found;
  logic                  fire;
  logic [ID_W-1:0]       grant_id;
  logic [DATA_WIDTH-1:0] payload;
  logic                  done_bad_id;
  logic                  done_zero;
  logic                  dec_any;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = enable & req_valid[i] & (credit[i] < CNT_W'(MAX_CREDIT));
    end
  end

  // Search starts at rr_ptr and wraps; saturated requesters are simply not eligible.
  always_comb begin : rr_search
    int idx;
    found    = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && eligible[j]) begin
          found    = 1'b1;
          grant_id = ID_W'(j);
        end
      end
    end
  end

  assign fire = found & fifo_full_n & reset_n;

  always_comb begin
    grant   = '0;
    payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = fire && (grant_id == ID_W'(i));
      if (grant_id == ID_W'(i)) payload = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign req_ready  = grant;
  assign fifo_write = fire;
  assign fifo_din   = {grant_id, payload};

  always_comb begin
    done_bad_id = done_valid && (int'(done_id) >= NUM_REQ);
    done_zero   = 1'b0;
    dec         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec[i] = done_valid && (done_id == ID_W'(i)) && (credit[i] != '0);
      if (done_valid && (done_id == ID_W'(i)) && (credit[i] == '0)) done_zero = 1'b1;
    end
  end

  assign dec_any = |dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) credit[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && !dec[i]) begin
          credit[i] <= credit[i] + CNT_W'(1);
        end else if (dec[i] && !grant[i]) begin
          credit[i] <= credit[i] - CNT_W'(1);
        end
      end
    end
  end

  // The total mirrors the credit sum; a grant and a retire in one cycle cancel even across requesters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else if (fire && !dec_any) begin
      outstanding <= outstanding + TOT_W'(1);
    end else if (dec_any && !fire) begin
      outstanding <= outstanding - TOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (fire) begin
      rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_underflow <= 1'b0;
    end else if (done_bad_id || done_zero) begin
      err_underflow <= 1'b1;
    end
  end

  assign idle = (outstanding == '0) && !fire;

`ifdef KCORE_START_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
      if ((|eligible) && !fifo_full_n && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_kcore_start_token_arbiter.sv
// Scoreboard bench for kcore_start_token_arbiter: a queue-based reference model predicts every cycle,
// a monitor compares; a second NUM_REQ=3 instance covers the out-of-range done_id error.
module tb_kcore_start_token_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int DW   = 1;
  localparam int MAXC = 4;
  localparam int TOTW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic fifo_full_n = 1'b0;
  logic done_valid = 1'b0;
  logic [IDW-1:0] done_id = '0;
  logic [N-1:0] req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic fifo_write;
  logic [IDW+DW-1:0] fifo_din;
  logic [TOTW-1:0] outstanding;
  logic idle;
  logic err_underflow;

  logic done_valid3 = 1'b0;
  logic [1:0] done_id3 = '0;
  logic [2:0] req_ready3;
  logic fifo_write3;
  logic [2:0] fifo_din3;
  logic [4:0] outstanding3;
  logic idle3;
  logic err3;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         write;
    logic [N-1:0] ready;
    int         out;
    bit         idle;
    bit         err;
  } status_t;

  status_t status_q[$];
  logic [IDW+DW-1:0] din_q[$];

  int m_credit[N];
  int m_rr;
  bit m_err;

  always #5 clk = ~clk;

  kcore_start_token_arbiter #(
    .NUM_REQ(N), .ID_W(IDW), .DATA_WIDTH(DW), .MAX_CREDIT(MAXC), .CNT_W(3), .TOT_W(TOTW)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full_n(fifo_full_n), .fifo_write(fifo_write), .fifo_din(fifo_din),
    .done_valid(done_valid), .done_id(done_id), .outstanding(outstanding), .idle(idle),
    .err_underflow(err_underflow)
  );

  kcore_start_token_arbiter #(
    .NUM_REQ(3), .ID_W(2), .DATA_WIDTH(1), .MAX_CREDIT(4), .CNT_W(3), .TOT_W(5)
  ) u_dut3 (
    .clk(clk), .reset_n(reset_n), .enable(1'b1), .req_valid(3'b000), .req_data(3'b000),
    .req_ready(req_ready3), .fifo_full_n(1'b1), .fifo_write(fifo_write3), .fifo_din(fifo_din3),
    .done_valid(done_valid3), .done_id(done_id3), .outstanding(outstanding3), .idle(idle3),
    .err_underflow(err3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, predict this cycle's outputs, then advance the model.
  task automatic applyStimulus(input bit rst, input bit en, input logic [N-1:0] v,
                               input logic [N-1:0] d, input bit fn, input bit dv, input int did);
    status_t s;
    int g;
    int idx;
    int sum;
    bit dec;
    logic [N-1:0] sh;
    @(negedge clk);
    reset_n     = !rst;
    enable      = en;
    req_valid   = v;
    req_data    = d;
    fifo_full_n = fn;
    done_valid  = dv;
    done_id     = IDW'(did);
    if (rst) begin
      for (int i = 0; i < N; i++) m_credit[i] = 0;
      m_rr  = 0;
      m_err = 1'b0;
    end
    g = -1;
    if (!rst && fn && en) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && v[idx] && m_credit[idx] < MAXC) g = idx;
      end
    end
    sum = 0;
    for (int i = 0; i < N; i++) sum += m_credit[i];
    s.write = (g >= 0);
    s.ready = (g >= 0) ? (N'(1) << g) : '0;
    s.out   = sum;
    s.idle  = (sum == 0) && (g < 0);
    s.err   = m_err;
    status_q.push_back(s);
    if (g >= 0) begin
      sh = d >> g;
      din_q.push_back({IDW'(g), sh[0]});
    end
    if (!rst) begin
      dec = dv && (did < N) && (m_credit[did] > 0);
      if (dv && ((did >= N) || (m_credit[did] == 0))) m_err = 1'b1;
      if (g >= 0) begin
        m_credit[g]++;
        m_rr = (g + 1) % N;
      end
      if (dec) m_credit[did]--;
    end
  endtask

  // Monitor: per-cycle status every cycle, FIFO words whenever the DUT writes.
  initial begin : monitor
    status_t s;
    logic [IDW+DW-1:0] exp_din;
    forever begin
      @(negedge clk);
      #2;
      if (status_q.size() > 0) begin
        s = status_q.pop_front();
        checkOutput("fifo_write", 32'(fifo_write), 32'(s.write));
        checkOutput("req_ready", 32'(req_ready), 32'(s.ready));
        checkOutput("outstanding", 32'(outstanding), 32'(s.out));
        checkOutput("idle", 32'(idle), 32'(s.idle));
        checkOutput("err_underflow", 32'(err_underflow), 32'(s.err));
        if (fifo_write === 1'b1) begin
          if (din_q.size() == 0) begin
            checkOutput("unexpected_write", 32'(1), 32'(0));
          end else begin
            exp_din = din_q.pop_front();
            checkOutput("fifo_din", 32'(fifo_din), 32'(exp_din));
          end
        end
      end
    end
  end

  initial begin : stimulus
    int did;
    bit dv;
    // Reset, then all four requesting: grants 0,1,2,3,0.
    applyStimulus(1, 0, '0, '0, 1, 0, 0);
    applyStimulus(1, 0, '0, '0, 1, 0, 0);
    for (int c = 0; c < 5; c++) applyStimulus(0, 1, 4'hF, N'($urandom), 1, 0, 0);
    // Backpressure with rr_ptr=1 and requesters 1 and 3 pending.
    for (int c = 0; c < 3; c++) applyStimulus(0, 1, 4'b1010, 4'b1010, 0, 0, 0);
    applyStimulus(0, 1, 4'b1010, 4'b0010, 1, 0, 0);
    applyStimulus(0, 1, 4'b1000, 4'b1000, 1, 0, 0);
    // Grant and retire of requester 0 in the same cycle.
    applyStimulus(0, 1, 4'b0001, 4'b0001, 1, 1, 0);
    // Requester 2 runs into its credit cap, then one retire frees one slot.
    for (int c = 0; c < 5; c++) applyStimulus(0, 1, 4'b0100, N'($urandom), 1, 0, 0);
    applyStimulus(0, 1, 4'b0100, 4'b0100, 1, 1, 2);
    applyStimulus(0, 1, 4'b0100, 4'b0100, 1, 0, 0);
    applyStimulus(0, 1, 4'b0100, 4'b0100, 1, 0, 0);

    applyStimulus(1, 0, '0, '0, 1, 0, 0);
    // Random traffic with only legal retires.
    for (int c = 0; c < 400; c++) begin
      did = int'($urandom_range(0, N - 1));
      dv  = ($urandom_range(0, 1) == 1) && (m_credit[did] > 0);
      applyStimulus(0, ($urandom_range(0, 7) != 0), N'($urandom), N'($urandom),
                    ($urandom_range(0, 3) != 0), dv, did);
    end
    // Drain with grants disabled until idle.
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < MAXC && m_credit[i] > 0; c++) applyStimulus(0, 0, 4'hF, 4'hF, 1, 1, i);
    end
    applyStimulus(0, 0, 4'hF, 4'hF, 1, 0, 0);
    // Retire for a requester holding no credit: sticky error.
    applyStimulus(0, 0, 4'h0, 4'h0, 1, 1, 1);
    for (int c = 0; c < 3; c++) applyStimulus(0, 1, 4'h2, 4'h2, 1, 0, 0);

    // Out-of-range done_id on the three-requester instance.
    checkOutput("err3_before", 32'(err3), 32'(0));
    done_valid3 = 1'b1;
    done_id3    = 2'd3;
    applyStimulus(0, 1, 4'h0, 4'h0, 1, 0, 0);
    done_valid3 = 1'b0;
    #2;
    checkOutput("err3_set", 32'(err3), 32'(1));
    applyStimulus(0, 1, 4'h0, 4'h0, 1, 0, 0);
    #2;
    checkOutput("err3_sticky", 32'(err3), 32'(1));
    checkOutput("err3_outstanding", 32'(outstanding3), 32'(0));

    // Reset asserted mid-stream with all requesters pending.
    for (int c = 0; c < 3; c++) applyStimulus(0, 1, 4'hF, N'($urandom), 1, 0, 0);
    applyStimulus(1, 1, 4'hF, 4'hF, 1, 0, 0);
    applyStimulus(1, 1, 4'hF, 4'hF, 1, 0, 0);
    applyStimulus(0, 1, 4'hF, 4'hA, 1, 0, 0);
    applyStimulus(0, 1, 4'hF, 4'hA, 1, 0, 0);

    @(negedge clk);
    #4;
    checkOutput("din_queue_empty", 32'(din_q.size()), 32'(0));
    checkOutput("status_queue_empty", 32'(status_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
